decommutator: RTL

DECOMMUTATOR -- requirements
Module: decommutator

---
 rtl/decommutator_pkg.sv | 28 ++
 rtl/decommutator_route_table.sv | 42 ++++
 rtl/decommutator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/decommutator_pkg.sv
// Shared types and constants for the decommutator: route entries, FSM states
// and the bit-reversed destination decode.
package decommutator_pkg;

  localparam int N_IN   = 3;
  localparam int N_OUT  = 8;
  localparam int DEST_W = 3;

  typedef struct packed {
    logic              en;
    logic [DEST_W-1:0] dest;
  } route_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // Destination codes arrive in the commutator's control encoding, LSB first.
  function automatic logic [DEST_W-1:0] dest_line(input logic [DEST_W-1:0] code);
    logic [DEST_W-1:0] line;
    for (int b = 0; b < DEST_W; b++) begin
      line[b] = code[DEST_W-1-b];
    end
    return line;
  endfunction

endpackage

// File: rtl/decommutator_route_table.sv
// Shadow/active route tables: writes land in shadow, load copies shadow to active.
// Latency: one edge for a write, one edge for a load.
// Backpressure: none here; the caller only writes while it is accepting.
module decommutator_route_table
  import decommutator_pkg::*;
#(
  parameter int N_ROUTES = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en,
  input  logic [1:0]             wr_sel,
  input  route_t                 wr_route,
  input  logic                   load,
  output route_t [N_ROUTES-1:0]  shadow_o,
  output route_t [N_ROUTES-1:0]  active_o
);

  route_t [N_ROUTES-1:0] shadow_q;
  route_t [N_ROUTES-1:0] active_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      // Out-of-range selects match no entry and are dropped here.
      for (int i = 0; i < N_ROUTES; i++) begin
        if (wr_en && (wr_sel == 2'(i))) begin
          shadow_q[i] <= wr_route;
        end
      end
      if (load) begin
        active_q <= shadow_q;
      end
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/decommutator.sv
// Routes each input line to a configurable output line through a committed route table.
// Latency: outputs one cycle after inputs; a commit takes effect two edges after commit_i.
// Backpressure: cfg_ready_o drops for the single COMMIT cycle and during reset.
module decommutator #(
  parameter int N_IN  = decommutator_pkg::N_IN,
  parameter int N_OUT = decommutator_pkg::N_OUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_sel_i,
  input  logic             cfg_en_i,
  input  logic [2:0]       cfg_dest_i,
  input  logic             commit_i,
  input  logic [N_IN-1:0]  inputs_i,
  output logic [N_OUT-1:0] outputs_o,
  output logic             collision_o,
  output logic             cfg_err_o
);

  import decommutator_pkg::*;

  state_t             state_q, state_d;
  logic               accept;
  logic               load;
  logic               illegal_sel;
  route_t             wr_route;
  route_t [N_IN-1:0]  shadow;
  route_t [N_IN-1:0]  active;
  logic [N_OUT-1:0]   routed;
  logic [N_OUT-1:0]   outputs_q;
  logic               shadow_collision;
  logic               collision_q;
  logic               cfg_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready_o = !rst_i;
        if (commit_i) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept      = cfg_valid_i && cfg_ready_o;
  assign illegal_sel = int'(cfg_sel_i) >= N_IN;
  assign wr_route    = '{en: cfg_en_i, dest: cfg_dest_i};

  decommutator_route_table #(
    .N_ROUTES (N_IN)
  ) u_route_table (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (accept),
    .wr_sel   (cfg_sel_i),
    .wr_route (wr_route),
    .load     (load),
    .shadow_o (shadow),
    .active_o (active)
  );

  // Walk routes from high to low index so the lowest enabled route wins.
  always_comb begin
    routed = '0;
    for (int k = 0; k < N_OUT; k++) begin
      for (int j = N_IN - 1; j >= 0; j--) begin
        if (active[j].en && (int'(dest_line(active[j].dest)) == k)) begin
          routed[k] = inputs_i[j];
        end
      end
    end
  end

  // Evaluated on the shadow so the flag lands on the same edge as the load.
  always_comb begin
    shadow_collision = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      for (int j = i + 1; j < N_IN; j++) begin
        if (shadow[i].en && shadow[j].en && (shadow[i].dest == shadow[j].dest)) begin
          shadow_collision = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outputs_q   <= '0;
      collision_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      outputs_q <= routed;
      if (load) begin
        collision_q <= shadow_collision;
      end
      if (accept && illegal_sel) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  assign outputs_o   = outputs_q;
  assign collision_o = collision_q;
  assign cfg_err_o   = cfg_err_q;

endmodule
